// File: rtl/cpu_decode.sv
`timescale 1ns/1ps
// cpu_decode: decode/issue stage between instruction fetch and execute.
// Consumes fetch words, resolves JMP locally by redirecting fetch, applies
// execute-stage redirects, and issues every other word to execute.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_valid_i, inst_i        fetch word and its valid
//   fetch_pc_i                  fetch next-PC (word PC is fetch_pc_i - 1)
//   read_inst_o                 consume presented word (combinational)
//   wr_pc_o, pc_o               one-cycle fetch redirect strobe and target
//   ex_redirect_i, ex_target_i  execute-stage taken branch and target
//   dec_valid_o, ex_ready_i     decoded-word handshake to execute
//   dec_op_o .. dec_pc_o        registered decoded fields
//   issue_cnt_o                 saturating count of issued words
module cpu_decode #(
    parameter int unsigned PCW  = 19,
    parameter int unsigned CNTW = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_valid_i,
    input  logic [31:0]      inst_i,
    input  logic [PCW-1:0]   fetch_pc_i,
    output logic             read_inst_o,
    output logic             wr_pc_o,
    output logic [PCW-1:0]   pc_o,
    input  logic             ex_redirect_i,
    input  logic [PCW-1:0]   ex_target_i,
    output logic             dec_valid_o,
    input  logic             ex_ready_i,
    output logic [5:0]       dec_op_o,
    output logic [4:0]       dec_rd_o,
    output logic [4:0]       dec_rs1_o,
    output logic [4:0]       dec_rs2_o,
    output logic [31:0]      dec_imm_o,
    output logic [PCW-1:0]   dec_pc_o,
    output logic [CNTW-1:0]  issue_cnt_o
);

    localparam int unsigned OPW  = 6;
    localparam int unsigned IMMW = 16;
    localparam logic [OPW-1:0]  OP_JMP  = 6'h02;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t state;
    logic   is_jmp;

    // Consume only in RUN, when the output register is free or draining,
    // and never while a redirect is in flight.
    assign read_inst_o = (state == ST_RUN) & inst_valid_i
                       & (~dec_valid_o | ex_ready_i)
                       & ~ex_redirect_i & ~wr_pc_o;

    assign is_jmp = (inst_i[31:26] == OP_JMP);

    // State, redirect strobe, output register and issue counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_FLUSH;
            wr_pc_o     <= 1'b0;
            pc_o        <= '0;
            dec_valid_o <= 1'b0;
            dec_op_o    <= '0;
            dec_rd_o    <= '0;
            dec_rs1_o   <= '0;
            dec_rs2_o   <= '0;
            dec_imm_o   <= '0;
            dec_pc_o    <= '0;
            issue_cnt_o <= '0;
        end else begin
            wr_pc_o <= 1'b0;
            if (ex_redirect_i) begin
                // Execute redirect wins over everything, including a held word.
                dec_valid_o <= 1'b0;
                wr_pc_o     <= 1'b1;
                pc_o        <= ex_target_i;
                state       <= ST_FLUSH;
            end else if (read_inst_o) begin
                if (is_jmp) begin
                    dec_valid_o <= 1'b0;
                    wr_pc_o     <= 1'b1;
                    pc_o        <= inst_i[PCW-1:0];
                    state       <= ST_FLUSH;
                end else begin
                    dec_valid_o <= 1'b1;
                    dec_op_o    <= inst_i[31:26];
                    dec_rd_o    <= inst_i[25:21];
                    dec_rs1_o   <= inst_i[20:16];
                    dec_rs2_o   <= inst_i[15:11];
                    dec_imm_o   <= {{(32-IMMW){inst_i[IMMW-1]}}, inst_i[IMMW-1:0]};
                    dec_pc_o    <= fetch_pc_i - PCW'(1);
                    if (issue_cnt_o != CNT_MAX) begin
                        issue_cnt_o <= issue_cnt_o + CNTW'(1);
                    end
                end
            end else begin
                if (ex_ready_i) begin
                    dec_valid_o <= 1'b0;
                end
                // Fetch shows one blank cycle after the strobe; that marks the
                // end of the wrong-path words.
                if ((state == ST_FLUSH) && !wr_pc_o && !inst_valid_i) begin
                    state <= ST_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_decode.sv
`timescale 1ns/1ps
// tb_cpu_decode: directed scenarios plus a randomized program run against a
// program-walk reference model with a fetch emulator.
module tb_cpu_decode;

    localparam int unsigned PCW  = 19;
    localparam int unsigned CNTW = 16;
    localparam int unsigned NEXP = 300;

    logic            clk;
    logic            resetn;
    logic            inst_valid_i;
    logic [31:0]     inst_i;
    logic [PCW-1:0]  fetch_pc_i;
    logic            read_inst_o;
    logic            wr_pc_o;
    logic [PCW-1:0]  pc_o;
    logic            ex_redirect_i;
    logic [PCW-1:0]  ex_target_i;
    logic            dec_valid_o;
    logic            ex_ready_i;
    logic [5:0]      dec_op_o;
    logic [4:0]      dec_rd_o;
    logic [4:0]      dec_rs1_o;
    logic [4:0]      dec_rs2_o;
    logic [31:0]     dec_imm_o;
    logic [PCW-1:0]  dec_pc_o;
    logic [CNTW-1:0] issue_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_decode #(.PCW(PCW), .CNTW(CNTW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .fetch_pc_i   (fetch_pc_i),
        .read_inst_o  (read_inst_o),
        .wr_pc_o      (wr_pc_o),
        .pc_o         (pc_o),
        .ex_redirect_i(ex_redirect_i),
        .ex_target_i  (ex_target_i),
        .dec_valid_o  (dec_valid_o),
        .ex_ready_i   (ex_ready_i),
        .dec_op_o     (dec_op_o),
        .dec_rd_o     (dec_rd_o),
        .dec_rs1_o    (dec_rs1_o),
        .dec_rs2_o    (dec_rs2_o),
        .dec_imm_o    (dec_imm_o),
        .dec_pc_o     (dec_pc_o),
        .issue_cnt_o  (issue_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn        = 1'b0;
        inst_valid_i  = 1'b0;
        ex_redirect_i = 1'b0;
        ex_ready_i    = 1'b1;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        inst_valid_i  = 1'b1;
        inst_i        = 32'h0421_8000;
        fetch_pc_i    = PCW'(1);
        ex_redirect_i = 1'b0;
        ex_target_i   = '0;
        ex_ready_i    = 1'b1;
        step();
        step();
        n_checks++;
        if ({read_inst_o, wr_pc_o, dec_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rd/wr/valid=%b expected 000", {read_inst_o, wr_pc_o, dec_valid_o});
        end
        n_checks++;
        if ({pc_o, dec_pc_o, issue_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_pc_cnt: got pc=%h dec_pc=%h cnt=%h expected 0", pc_o, dec_pc_o, issue_cnt_o);
        end
        n_checks++;
        if ({dec_op_o, dec_rd_o, dec_rs1_o, dec_rs2_o, dec_imm_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got op=%h rd=%h rs1=%h rs2=%h imm=%h expected 0",
                     dec_op_o, dec_rd_o, dec_rs1_o, dec_rs2_o, dec_imm_o);
        end
        // First cycle out of reset is FLUSH: a valid word must not be taken.
        resetn = 1'b1;
        #1;
        n_checks++;
        if (read_inst_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_read: got %b expected 0", read_inst_o);
        end
        step();
        inst_valid_i = 1'b0;
        step();
    endtask

    task automatic test_alu();
        inst_valid_i = 1'b1;
        inst_i       = 32'h0421_8000;
        fetch_pc_i   = PCW'(1);
        ex_ready_i   = 1'b1;
        #1;
        n_checks++;
        if (read_inst_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_read0: got %b expected 1", read_inst_o);
        end
        step();
        n_checks++;
        if ({dec_valid_o, dec_op_o, dec_rd_o, dec_rs1_o, dec_rs2_o} !== {1'b1, 6'd1, 5'd1, 5'd1, 5'd16}) begin
            n_fail++;
            $display("FAIL alu_fields0: got v=%b op=%0d rd=%0d rs1=%0d rs2=%0d expected 1 1 1 1 16",
                     dec_valid_o, dec_op_o, dec_rd_o, dec_rs1_o, dec_rs2_o);
        end
        n_checks++;
        if ({dec_imm_o, dec_pc_o, issue_cnt_o} !== {32'hFFFF_8000, 19'd0, 16'd1}) begin
            n_fail++;
            $display("FAIL alu_imm0: got imm=%h pc=%h cnt=%0d expected ffff8000 0 1", dec_imm_o, dec_pc_o, issue_cnt_o);
        end
        inst_i     = 32'h0442_0005;
        fetch_pc_i = PCW'(2);
        step();
        n_checks++;
        if ({dec_valid_o, dec_rd_o, dec_imm_o, dec_pc_o, issue_cnt_o} !== {1'b1, 5'd2, 32'h0000_0005, 19'd1, 16'd2}) begin
            n_fail++;
            $display("FAIL alu_word1: got v=%b rd=%0d imm=%h pc=%h cnt=%0d expected 1 2 00000005 1 2",
                     dec_valid_o, dec_rd_o, dec_imm_o, dec_pc_o, issue_cnt_o);
        end
        inst_valid_i = 1'b0;
        step();
        n_checks++;
        if ({dec_valid_o, issue_cnt_o} !== {1'b0, 16'd2}) begin
            n_fail++;
            $display("FAIL alu_drain: got v=%b cnt=%0d expected 0 2", dec_valid_o, issue_cnt_o);
        end
    endtask

    task automatic test_stall();
        inst_valid_i = 1'b1;
        inst_i       = 32'h0C63_1234;
        fetch_pc_i   = PCW'(11);
        ex_ready_i   = 1'b1;
        step();
        ex_ready_i = 1'b0;
        inst_i     = 32'h1084_FFFE;
        fetch_pc_i = PCW'(12);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (read_inst_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_read%0d: got %b expected 0", i, read_inst_o);
            end
            step();
            n_checks++;
            if ({dec_valid_o, dec_op_o, dec_rd_o, dec_imm_o, dec_pc_o, issue_cnt_o} !==
                {1'b1, 6'd3, 5'd3, 32'h0000_1234, 19'd10, 16'd3}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b op=%0d rd=%0d imm=%h pc=%h cnt=%0d expected 1 3 3 00001234 a 3",
                         i, dec_valid_o, dec_op_o, dec_rd_o, dec_imm_o, dec_pc_o, issue_cnt_o);
            end
        end
        ex_ready_i = 1'b1;
        #1;
        n_checks++;
        if (read_inst_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_read: got %b expected 1", read_inst_o);
        end
        step();
        n_checks++;
        if ({dec_valid_o, dec_op_o, dec_rd_o, dec_rs1_o, dec_imm_o, dec_pc_o, issue_cnt_o} !==
            {1'b1, 6'd4, 5'd4, 5'd4, 32'hFFFF_FFFE, 19'd11, 16'd4}) begin
            n_fail++;
            $display("FAIL stall_next: got v=%b op=%0d rd=%0d rs1=%0d imm=%h pc=%h cnt=%0d expected 1 4 4 4 fffffffe b 4",
                     dec_valid_o, dec_op_o, dec_rd_o, dec_rs1_o, dec_imm_o, dec_pc_o, issue_cnt_o);
        end
        inst_valid_i = 1'b0;
        step();
        n_checks++;
        if ({dec_valid_o, issue_cnt_o} !== {1'b0, 16'd4}) begin
            n_fail++;
            $display("FAIL stall_drain: got v=%b cnt=%0d expected 0 4", dec_valid_o, issue_cnt_o);
        end
    endtask

    task automatic test_jmp();
        inst_valid_i = 1'b1;
        inst_i       = 32'h0800_0040;
        fetch_pc_i   = PCW'(6);
        ex_ready_i   = 1'b1;
        #1;
        n_checks++;
        if (read_inst_o !== 1'b1) begin
            n_fail++;
            $display("FAIL jmp_read: got %b expected 1", read_inst_o);
        end
        step();
        n_checks++;
        if ({wr_pc_o, pc_o, dec_valid_o, issue_cnt_o} !== {1'b1, 19'h40, 1'b0, 16'd4}) begin
            n_fail++;
            $display("FAIL jmp_strobe: got wr=%b pc=%h v=%b cnt=%0d expected 1 40 0 4", wr_pc_o, pc_o, dec_valid_o, issue_cnt_o);
        end
        inst_i     = 32'h0421_8000;
        fetch_pc_i = PCW'(7);
        #1;
        n_checks++;
        if (read_inst_o !== 1'b0) begin
            n_fail++;
            $display("FAIL jmp_stale_read: got %b expected 0", read_inst_o);
        end
        step();
        n_checks++;
        if ({wr_pc_o, dec_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL jmp_after: got wr/v=%b expected 00", {wr_pc_o, dec_valid_o});
        end
        inst_valid_i = 1'b0;
        step();
        inst_valid_i = 1'b1;
        inst_i       = 32'h0442_0005;
        fetch_pc_i   = PCW'(19'h41);
        #1;
        n_checks++;
        if (read_inst_o !== 1'b1) begin
            n_fail++;
            $display("FAIL jmp_resume_read: got %b expected 1", read_inst_o);
        end
        step();
        n_checks++;
        if ({dec_valid_o, dec_pc_o, issue_cnt_o} !== {1'b1, 19'h40, 16'd5}) begin
            n_fail++;
            $display("FAIL jmp_target_word: got v=%b pc=%h cnt=%0d expected 1 40 5", dec_valid_o, dec_pc_o, issue_cnt_o);
        end
        inst_valid_i = 1'b0;
        step();
    endtask

    task automatic test_redirect_stall();
        inst_valid_i = 1'b1;
        inst_i       = 32'h0C63_1234;
        fetch_pc_i   = PCW'(19'h42);
        ex_ready_i   = 1'b1;
        step();
        ex_ready_i = 1'b0;
        inst_i     = 32'h1084_FFFE;
        fetch_pc_i = PCW'(19'h43);
        step();
        ex_redirect_i = 1'b1;
        ex_target_i   = PCW'(19'h123);
        #1;
        n_checks++;
        if (read_inst_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_stall_read: got %b expected 0", read_inst_o);
        end
        step();
        ex_redirect_i = 1'b0;
        n_checks++;
        if ({dec_valid_o, wr_pc_o, pc_o, issue_cnt_o} !== {1'b0, 1'b1, 19'h123, 16'd6}) begin
            n_fail++;
            $display("FAIL redir_stall: got v=%b wr=%b pc=%h cnt=%0d expected 0 1 123 6", dec_valid_o, wr_pc_o, pc_o, issue_cnt_o);
        end
        step();
        n_checks++;
        if (wr_pc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_stall_once: got wr=%b expected 0", wr_pc_o);
        end
        inst_valid_i = 1'b0;
        ex_ready_i   = 1'b1;
        step();
    endtask

    task automatic test_redirect_vs_jmp();
        inst_valid_i  = 1'b1;
        inst_i        = 32'h0800_0040;
        fetch_pc_i    = PCW'(19'h124);
        ex_redirect_i = 1'b1;
        ex_target_i   = PCW'(19'h10);
        step();
        ex_redirect_i = 1'b0;
        n_checks++;
        if ({wr_pc_o, pc_o} !== {1'b1, 19'h10}) begin
            n_fail++;
            $display("FAIL redir_jmp_strobe: got wr=%b pc=%h expected 1 10", wr_pc_o, pc_o);
        end
        step();
        n_checks++;
        if ({wr_pc_o, pc_o, issue_cnt_o} !== {1'b0, 19'h10, 16'd6}) begin
            n_fail++;
            $display("FAIL redir_jmp_single: got wr=%b pc=%h cnt=%0d expected 0 10 6", wr_pc_o, pc_o, issue_cnt_o);
        end
        inst_valid_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back_redirect();
        ex_redirect_i = 1'b1;
        ex_target_i   = PCW'(19'h20);
        step();
        n_checks++;
        if ({wr_pc_o, pc_o} !== {1'b1, 19'h20}) begin
            n_fail++;
            $display("FAIL b2b_first: got wr=%b pc=%h expected 1 20", wr_pc_o, pc_o);
        end
        ex_target_i = PCW'(19'h30);
        step();
        ex_redirect_i = 1'b0;
        n_checks++;
        if ({wr_pc_o, pc_o} !== {1'b1, 19'h30}) begin
            n_fail++;
            $display("FAIL b2b_second: got wr=%b pc=%h expected 1 30", wr_pc_o, pc_o);
        end
        inst_valid_i = 1'b1;
        step();
        n_checks++;
        if (wr_pc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got wr=%b expected 0", wr_pc_o);
        end
        inst_valid_i = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        inst_valid_i = 1'b1;
        inst_i       = 32'h0C63_1234;
        fetch_pc_i   = PCW'(19'h31);
        ex_ready_i   = 1'b0;
        step();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({dec_valid_o, wr_pc_o, read_inst_o, pc_o, dec_pc_o, issue_cnt_o, dec_imm_o, dec_op_o, dec_rd_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b wr=%b rd=%b pc=%h dpc=%h cnt=%0d imm=%h expected all 0",
                     dec_valid_o, wr_pc_o, read_inst_o, pc_o, dec_pc_o, issue_cnt_o, dec_imm_o);
        end
        inst_valid_i = 1'b0;
        ex_ready_i   = 1'b1;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0]    mem [64];
        bit             isjmp [64];
        logic [PCW-1:0] exp_pc [$];
        logic [31:0]    exp_inst [$];
        logic [PCW-1:0] wpc;
        logic [PCW-1:0] tgt;
        logic [31:0]    w;
        logic [71:0]    got;
        logic [71:0]    want;
        int unsigned    fpc;
        int unsigned    accepted;
        int unsigned    cycles;
        int unsigned    op;
        int unsigned    t;
        bit             blank_next;
        bit             prev_wr;

        apply_reset();
        for (int i = 0; i < 64; i++) isjmp[i] = (i != 0) && ($urandom_range(0, 5) == 0);
        for (int i = 0; i < 64; i++) begin
            if (isjmp[i]) begin
                t = $urandom_range(0, 63);
                while (isjmp[t]) t = $urandom_range(0, 63);
                mem[i] = {6'h02, 7'($urandom), 19'(t)};
            end else begin
                op = $urandom_range(0, 63);
                if (op == 2) op = 3;
                mem[i] = {6'(op), 26'($urandom)};
            end
        end
        // Expected issue stream: walk the program, following JMPs.
        wpc = '0;
        while (exp_pc.size() < NEXP) begin
            w = mem[wpc[5:0]];
            if (w[31:26] == 6'h02) begin
                wpc = w[PCW-1:0];
            end else begin
                exp_pc.push_back(wpc);
                exp_inst.push_back(w);
                wpc = wpc + PCW'(1);
            end
        end

        fpc        = 0;
        tgt        = '0;
        blank_next = 1'b1;
        prev_wr    = 1'b0;
        accepted   = 0;
        cycles     = 0;
        while (accepted < NEXP && cycles < 5000) begin
            cycles++;
            if (blank_next) begin
                inst_valid_i = 1'b0;
                fpc          = int'(tgt);
                blank_next   = 1'b0;
            end else begin
                inst_valid_i = ($urandom_range(0, 7) != 0);
                inst_i       = mem[fpc % 64];
                fetch_pc_i   = PCW'(fpc + 1);
            end
            if (wr_pc_o) begin
                n_checks++;
                if (prev_wr) begin
                    n_fail++;
                    $display("FAIL rnd_strobe_width: got wr_pc_o high 2 cycles expected 1");
                end
                blank_next = 1'b1;
                tgt        = pc_o;
            end
            prev_wr    = wr_pc_o;
            ex_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (dec_valid_o && ex_ready_i) begin
                n_checks++;
                got = {dec_op_o, dec_rd_o, dec_rs1_o, dec_rs2_o, dec_imm_o, dec_pc_o};
                if (exp_inst.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra: got unexpected issue pc=%h expected none", dec_pc_o);
                end else begin
                    w    = exp_inst.pop_front();
                    want = {w[31:26], w[25:21], w[20:16], w[15:11], {{16{w[15]}}, w[15:0]}, exp_pc.pop_front()};
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL rnd_issue%0d: got %h expected %h", accepted, got, want);
                    end
                end
                accepted++;
            end
            n_checks++;
            if (issue_cnt_o !== CNTW'(accepted + (dec_valid_o && !ex_ready_i ? 1 : 0))) begin
                n_fail++;
                $display("FAIL rnd_count: got %0d expected %0d", issue_cnt_o, accepted + (dec_valid_o && !ex_ready_i ? 1 : 0));
            end
            if (read_inst_o) fpc++;
            step();
        end
        n_checks++;
        if (accepted < NEXP) begin
            n_fail++;
            $display("FAIL rnd_timeout: got %0d issues expected %0d", accepted, NEXP);
        end
        inst_valid_i = 1'b0;
        ex_ready_i   = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        logic [CNTW-1:0] want [3];
        want[0] = 16'hFFFE;
        want[1] = 16'hFFFF;
        want[2] = 16'hFFFF;
        apply_reset();
        inst_valid_i = 1'b0;
        step();
        inst_valid_i = 1'b1;
        ex_ready_i   = 1'b1;
        inst_i       = 32'h0421_8000;
        for (int k = 0; k < 65533; k++) begin
            fetch_pc_i = PCW'(k + 1);
            step();
        end
        n_checks++;
        if (issue_cnt_o !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL sat_pre: got %h expected fffd", issue_cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            fetch_pc_i = PCW'(65534 + i);
            step();
            n_checks++;
            if (issue_cnt_o !== want[i]) begin
                n_fail++;
                $display("FAIL sat_%0d: got %h expected %h", i, issue_cnt_o, want[i]);
            end
        end
        inst_valid_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_stall();
        test_jmp();
        test_redirect_stall();
        test_redirect_vs_jmp();
        test_back_to_back_redirect();
        test_async_reset();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
